// File: rtl/harry_transition_mover_pkg.sv
// Shared types and screen constants for the level-transition sprite movers.
package transition_pkg;
    typedef enum logic [1:0] {IDLE, ENTER, HOVER, EXIT} harry_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic signed [11:0] coord_t;

    // Scan coordinates are unsigned 11-bit; widen with a zero sign bit.
    function automatic coord_t to_coord(input logic [10:0] p);
        return coord_t'({1'b0, p});
    endfunction
endpackage

// File: rtl/harry_transition_mover_if.sv
// Scan/handshake bundle between the transition mover and the Harry bitmap stage.
interface harry_transition_mover_if;
    logic        startOfFrame;
    logic        start;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        busy;
    logic        done;

    modport master (
        output startOfFrame, start, pixelX, pixelY,
        input  offsetX, offsetY, InsideRectangle, busy, done
    );

    modport slave (
        input  startOfFrame, start, pixelX, pixelY,
        output offsetX, offsetY, InsideRectangle, busy, done
    );
endinterface

// File: rtl/harry_transition_mover_sprite_rect_hit.sv
// Registered hit test of the scan pixel against a sprite box; emits box-relative offsets.
module sprite_rect_hit
    import transition_pkg::*;
#(
    parameter int OBJECT_WIDTH  = 64,
    parameter int OBJECT_HEIGHT = 38
) (
    input  logic        clk,
    input  logic        resetN,
    input  coord_t      topLeftX,
    input  coord_t      topLeftY,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        enable,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY
);
    coord_t px, py;
    logic   hit;

    // Signed compares keep the test correct while the box hangs off either edge.
    always_comb begin
        px  = to_coord(pixelX);
        py  = to_coord(pixelY);
        hit = enable
            && (px >= topLeftX) && (px < topLeftX + coord_t'(OBJECT_WIDTH))
            && (py >= topLeftY) && (py < topLeftY + coord_t'(OBJECT_HEIGHT));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            InsideRectangle <= hit;
            offsetX         <= hit ? 11'(px - topLeftX) : '0;
            offsetY         <= hit ? 11'(py - topLeftY) : '0;
        end
    end
endmodule

// File: rtl/harry_transition_mover.sv
// Flies the Harry sprite in from the left, hovers with a small bob, flies it out right.
module harry_transition_mover
    import transition_pkg::*;
#(
    parameter int OBJECT_WIDTH  = 64,
    parameter int OBJECT_HEIGHT = 38,
    parameter int START_X       = -64,
    parameter int HOVER_X       = 288,
    parameter int END_X         = 640,
    parameter int Y_TOP         = 200,
    parameter int SPEED         = 4,
    parameter int HOVER_FRAMES  = 60
) (
    input  logic                     clk,
    input  logic                     resetN,
    harry_transition_mover_if.slave  bus
);
    localparam int HC_W = $clog2(HOVER_FRAMES + 1);

    harry_state_t    state, state_n;
    coord_t          top_x, top_y, top_x_n, top_y_n, x_step;
    logic [HC_W-1:0] hover_cnt, hover_cnt_n;
    logic [3:0]      bob_cnt, bob_cnt_n;
    logic            done_n, busy_r, done_r;
    logic            enter_end, hover_end, exit_end;

    assign x_step    = top_x + coord_t'(SPEED);
    assign enter_end = bus.startOfFrame && (x_step >= coord_t'(HOVER_X));
    assign hover_end = bus.startOfFrame && (hover_cnt == HC_W'(HOVER_FRAMES - 1));
    assign exit_end  = bus.startOfFrame && (x_step >= coord_t'(END_X));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = ENTER;
            ENTER:   if (enter_end) state_n = HOVER;
            HOVER:   if (hover_end) state_n = EXIT;
            EXIT:    if (exit_end)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Position only changes on startOfFrame so a frame is never drawn half-moved.
    always_comb begin
        top_x_n     = top_x;
        top_y_n     = top_y;
        hover_cnt_n = hover_cnt;
        bob_cnt_n   = bob_cnt;
        done_n      = 1'b0;
        case (state)
            ENTER: if (bus.startOfFrame) begin
                top_x_n     = enter_end ? coord_t'(HOVER_X) : x_step;
                hover_cnt_n = '0;
            end
            HOVER: if (bus.startOfFrame) begin
                hover_cnt_n = hover_cnt + 1'b1;
                bob_cnt_n   = bob_cnt + 4'd1;
                top_y_n     = bob_cnt_n[3] ? coord_t'(Y_TOP + 2) : coord_t'(Y_TOP);
                if (hover_end) begin
                    top_y_n   = coord_t'(Y_TOP);
                    bob_cnt_n = '0;
                end
            end
            EXIT: if (bus.startOfFrame) begin
                top_x_n = exit_end ? coord_t'(START_X) : x_step;
                done_n  = exit_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            top_x     <= coord_t'(START_X);
            top_y     <= coord_t'(Y_TOP);
            hover_cnt <= '0;
            bob_cnt   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            top_x     <= top_x_n;
            top_y     <= top_y_n;
            hover_cnt <= hover_cnt_n;
            bob_cnt   <= bob_cnt_n;
            busy_r    <= (state_n != IDLE);
            done_r    <= done_n;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;

    sprite_rect_hit #(
        .OBJECT_WIDTH  (OBJECT_WIDTH),
        .OBJECT_HEIGHT (OBJECT_HEIGHT)
    ) u_hit (
        .clk             (clk),
        .resetN          (resetN),
        .topLeftX        (top_x),
        .topLeftY        (top_y),
        .pixelX          (bus.pixelX),
        .pixelY          (bus.pixelY),
        .enable          (state != IDLE),
        .InsideRectangle (bus.InsideRectangle),
        .offsetX         (bus.offsetX),
        .offsetY         (bus.offsetY)
    );
endmodule

// File: tb/tb_harry_transition_mover.sv
// Random scan stimulus against a frame-indexed position model of the Harry fly-through.
module tb_harry_transition_mover;
    localparam int W = 64, H = 38, START_X = -64, HOVER_X = 288, END_X = 640;
    localparam int Y_TOP = 200, SPEED = 4, HF = 60, FL = 8;
    localparam int K_E   = (HOVER_X - START_X + SPEED - 1) / SPEED;
    localparam int K_END = K_E + HF + (END_X - HOVER_X + SPEED - 1) / SPEED;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    harry_transition_mover_if bus();

    harry_transition_mover dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int   tests = 0, fails = 0;
    bit   m_active = 0;
    int   m_k = 0;
    logic exp_inside = 0, exp_busy = 0, exp_done = 0;
    int   exp_offx = 0, exp_offy = 0;
    bit   chk_en = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sprite top-left as a function of frames elapsed since start.
    function automatic void pos(input int k, output int x, output int y);
        int n;
        if (k < K_E) begin
            x = START_X + SPEED * k; y = Y_TOP;
        end else if (k <= K_E + HF) begin
            n = k - K_E;
            x = HOVER_X;
            y = (n < HF) ? Y_TOP + 2 * ((n >> 3) & 1) : Y_TOP;
        end else begin
            x = HOVER_X + SPEED * (k - K_E - HF); y = Y_TOP;
        end
    endfunction

    function automatic void cur_pos(output int x, output int y);
        if (m_active) pos(m_k, x, y);
        else begin x = START_X; y = Y_TOP; end
    endfunction

    task automatic step(input bit sof, input bit st, input int px, input int py);
        int x, y;
        bit hit;
        #1;
        bus.startOfFrame = sof; bus.start = st;
        bus.pixelX = px[10:0];  bus.pixelY = py[10:0];
        cur_pos(x, y);
        hit = m_active && px >= x && px < x + W && py >= y && py < y + H;
        exp_inside = hit;
        exp_offx = hit ? px - x : 0;
        exp_offy = hit ? py - y : 0;
        exp_done = 0;
        if (!m_active) begin
            if (st) begin m_active = 1; m_k = 0; end
        end else if (sof) begin
            m_k++;
            if (m_k == K_END) begin m_active = 0; exp_done = 1; end
        end
        exp_busy = m_active;
        @(negedge clk);
    endtask

    function automatic void rand_pix(output int px, output int py);
        int x, y;
        cur_pos(x, y);
        if ($urandom_range(1, 0) == 1) begin
            px = x + int'($urandom_range(W + 7, 0)) - 4;
            py = y + int'($urandom_range(H + 7, 0)) - 4;
        end else begin
            px = int'($urandom_range(639, 0));
            py = int'($urandom_range(479, 0));
        end
        if (px < 0) px = 0;
        if (px > 639) px = 639;
        if (py < 0) py = 0;
        if (py > 479) py = 479;
    endfunction

    task automatic frame(input int start_at);
        int px, py;
        for (int c = 0; c < FL; c++) begin
            rand_pix(px, py);
            step(c == 0, c == start_at, px, py);
        end
    endtask

    task automatic run_until(input int k);
        int guard = 0;
        while (m_active && m_k < k && guard < 400) begin
            frame(-1);
            guard++;
        end
    endtask

    task automatic probe(input string name, input int px, input int py,
                         input int e_in, input int e_ox, input int e_oy);
        step(0, 0, px, py);
        check({name, ".inside"}, 32'(bus.InsideRectangle), 32'(e_in));
        check({name, ".offsetX"}, 32'(bus.offsetX), 32'(e_ox));
        check({name, ".offsetY"}, 32'(bus.offsetY), 32'(e_oy));
    endtask

    task automatic do_reset();
        #1;
        resetN = 1'b0;
        bus.startOfFrame = 0; bus.start = 0; bus.pixelX = '0; bus.pixelY = '0;
        m_active = 0; m_k = 0;
        exp_inside = 0; exp_offx = 0; exp_offy = 0; exp_busy = 0; exp_done = 0;
        @(negedge clk);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.inside", 32'(bus.InsideRectangle), 32'd0);
        @(negedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model.inside", 32'(bus.InsideRectangle), 32'(exp_inside));
            check("model.offsetX", 32'(bus.offsetX), 32'(exp_offx));
            check("model.offsetY", 32'(bus.offsetY), 32'(exp_offy));
            check("model.busy", 32'(bus.busy), 32'(exp_busy));
            check("model.done", 32'(bus.done), 32'(exp_done));
        end
    end

    initial begin
        int px, py;
        resetN = 1'b0;
        bus.startOfFrame = 0; bus.start = 0; bus.pixelX = '0; bus.pixelY = '0;
        repeat (3) @(negedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);

        // Idle frames: nothing visible, not busy.
        frame(-1); frame(-1);
        check("idle.busy", 32'(bus.busy), 32'd0);

        // Start coinciding with startOfFrame: no move in that frame.
        step(1, 1, 0, 200);
        probe("sof_start_no_move", 0, 200, 0, 0, 0);
        for (int c = 2; c < FL; c++) begin rand_pix(px, py); step(0, 0, px, py); end
        frame(-1);
        probe("enter_k1", 0, 200, 1, 60, 0);

        run_until(10);
        probe("partial_left", 0, 200, 1, 24, 0);
        probe("partial_right_excl", 40, 200, 0, 0, 0);

        run_until(96);
        probe("hover_bob", 300, 205, 1, 12, 3);
        run_until(100);
        frame(3);
        check("hover_start_ignored.busy", 32'(bus.busy), 32'd1);

        run_until(147);
        probe("hover_last_bob", 288, 201, 0, 0, 0);
        frame(-1);
        probe("exit_entry_y", 288, 201, 1, 0, 1);
        frame(-1);
        probe("exit_moving", 288, 200, 0, 0, 0);

        run_until(K_END - 1);
        step(1, 0, 10, 10);
        check("final.done", 32'(bus.done), 32'd1);
        check("final.busy", 32'(bus.busy), 32'd0);
        step(0, 0, 10, 10);
        check("final.done_pulse", 32'(bus.done), 32'd0);
        for (int c = 2; c < FL; c++) begin rand_pix(px, py); step(0, 0, px, py); end

        // Second run, aborted by reset mid-EXIT.
        frame(-1);
        frame(5);
        run_until(200);
        do_reset();
        frame(-1); frame(-1);

        // Third run from a fresh reset position, to completion.
        frame(int'($urandom_range(FL - 1, 1)));
        frame(-1);
        probe("after_reset_k1", 0, 200, 1, 60, 0);
        run_until(K_END - 1);
        frame(-1);
        frame(-1); frame(-1);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
